// File: rtl/req_arbiter_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : req_arbiter_buffer_if                                         |
// | Purpose  : Bundles the upstream per-channel four-phase handshake and the |
// |            shared downstream request/ack port of req_arbiter_buffer.     |
// | Ports    : ireq[NUM_CH]  upstream request levels                         |
// |            oack[NUM_CH]  upstream acknowledge levels                     |
// |            oreq, oreq_ch downstream request level and owning channel     |
// |            ack           downstream one-cycle acknowledge pulse          |
// |            busy, timeout status outputs                                  |
// |            modport slave  : arbiter side                                 |
// |            modport master : requester / downstream side                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface req_arbiter_buffer_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0] ireq;
  logic [NUM_CH-1:0] oack;
  logic              oreq;
  logic [CH_W-1:0]   oreq_ch;
  logic              ack;
  logic              busy;
  logic              timeout;

  modport master (
    output ireq, ack,
    input  oack, oreq, oreq_ch, busy, timeout
  );

  modport slave (
    input  ireq, ack,
    output oack, oreq, oreq_ch, busy, timeout
  );
endinterface
`default_nettype wire

// File: rtl/req_arbiter_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : req_arbiter_buffer                                            |
// | Purpose  : Serialises four-phase handshakes from NUM_CH requesters onto  |
// |            one downstream request/ack port with round-robin arbitration. |
// |            Each channel runs its own IDLE/PEND/ACTIVE/DONE state.        |
// | Ports    : clk   clock, rising-edge                                      |
// |            reset asynchronous active-high reset                          |
// |            bus   req_arbiter_buffer_if.slave (ireq/oack/oreq/oreq_ch/    |
// |                  ack/busy/timeout)                                       |
// | Options  : `define REQ_ARBITER_BUFFER_TIMEOUT_EN to abort a granted      |
// |            request after TIMEOUT unacknowledged ACTIVE cycles.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module req_arbiter_buffer #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int TIMEOUT = 255
) (
  input  wire                   clk,
  input  wire                   reset,
  req_arbiter_buffer_if.slave   bus
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_pend   = 2'd1;
  localparam logic [1:0] c_active = 2'd2;
  localparam logic [1:0] c_done   = 2'd3;

  if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT < 1 || CH_W != $clog2(NUM_CH)) begin : g_bad_cfg
    $error("req_arbiter_buffer: illegal parameter set");
  end

  logic [NUM_CH-1:0] w_cand;
  logic [NUM_CH-1:0] w_active;
  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_win;
  logic              w_active_any;
  logic              w_to_fire;
  logic              w_grant_vld;
  logic [CH_W-1:0]   w_grant_idx;
  logic [CH_W-1:0]   w_oreq_ch;
  logic [CH_W-1:0]   r_last_grant;

  assign w_active_any = |w_active;

  // Round-robin search starting one past the last grant. A grant is only
  // issued when nothing was ACTIVE at the start of the cycle, which also
  // forces one idle oreq cycle between consecutive grants.
  always_comb begin
    logic            found;
    logic [CH_W-1:0] idx;
    found       = 1'b0;
    idx         = '0;
    w_grant_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(r_last_grant) + k) % NUM_CH);
      if (!found && w_cand[idx]) begin
        found       = 1'b1;
        w_grant_idx = idx;
      end
    end
    w_grant_vld = found && !w_active_any;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= CH_W'(NUM_CH - 1);
    end else if (w_grant_vld) begin
      r_last_grant <= w_grant_idx;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0] r_state;

    assign w_win[i]    = w_grant_vld && (w_grant_idx == CH_W'(i));
    assign w_cand[i]   = bus.ireq[i] && ((r_state == c_idle) || (r_state == c_pend));
    assign w_active[i] = (r_state == c_active);
    assign w_done[i]   = (r_state == c_done);
    assign w_busy[i]   = (r_state != c_idle);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= c_idle;
      end else begin
        case (r_state)
          c_idle:   if (bus.ireq[i]) r_state <= w_win[i] ? c_active : c_pend;
          c_pend:   if (!bus.ireq[i]) r_state <= c_idle;
                    else if (w_win[i]) r_state <= c_active;
          // ireq is deliberately ignored while the request is downstream
          c_active: if (bus.ack || w_to_fire) r_state <= c_done;
          c_done:   if (!bus.ireq[i]) r_state <= c_idle;
          default:  r_state <= c_idle;
        endcase
      end
    end
  end

  // At most one channel is ACTIVE, so OR-ing indices yields the owner.
  always_comb begin
    w_oreq_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_active[i]) w_oreq_ch = w_oreq_ch | CH_W'(i);
    end
  end

`ifdef REQ_ARBITER_BUFFER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_timeout;

  // Fires on the edge at which the count would reach TIMEOUT; a coincident
  // ack wins and is treated as a normal completion.
  assign w_to_fire = w_active_any && !bus.ack && (r_to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_fire;
      if (w_grant_vld) begin
        r_to_cnt <= '0;
      end else if (w_active_any && !bus.ack) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_to_fire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.oreq    = w_active_any;
  assign bus.oreq_ch = w_oreq_ch;
  assign bus.oack    = w_done;
  assign bus.busy    = |w_busy;

endmodule
`default_nettype wire
